// File: rtl/ddr3_avl_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_avl_pkg
// Shared types and constants for the picorv32-to-DDR3 EMIF Avalon-MM bridge.
//   state_e            : bridge sequencer states
//   ERR_WORD_DEFAULT   : read data returned when the EMIF never answers
//   WIN_BYTE_W         : byte-offset width of the 8 MiB DDR window
//   WORD_ADDR_W        : EMIF word-address width
//   DROP_W / DROP_MAX  : width and saturation value of the late-data counter
//   merge_bytes()      : byte-lane merge used by read-modify-write stores
// ---------------------------------------------------------------------------
package ddr3_avl_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_ISSUE  = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_RMW_ISSUE = 3'd4,
        ST_RMW_WAIT  = 3'd5,
        ST_WR_ISSUE  = 3'd6,
        ST_RESP      = 3'd7
    } state_e;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

    // 8 MiB window: 23-bit byte offset, of which bits [22:2] form the word address.
    localparam int WIN_BYTE_W  = 23;
    localparam int WORD_ADDR_W = 21;

    // Outstanding reads abandoned by a timeout; the count saturates.
    localparam int              DROP_W   = 3;
    localparam logic [DROP_W-1:0] DROP_MAX = 3'd7;

    // Per byte lane: take the store byte where its strobe is set, otherwise
    // keep the byte that was read back from memory.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ddr3_avl_bridge_if.sv
// ---------------------------------------------------------------------------
// ddr3_avl_bridge_if
// Bundles the picorv32 native memory bus and the EMIF Avalon-MM port that the
// bridge sits between.
//   slave  modport : the bridge's view (serves cpu requests, drives EMIF cmds)
//   master modport : the environment's view (cpu + EMIF driving the bridge)
// Signals:
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb : cpu request
//   mem_ready/mem_rdata                              : cpu completion
//   avl_address/avl_writedata/avl_read/avl_write     : EMIF command
//   avl_ready/avl_readdata/avl_readdatavalid         : EMIF response
// ---------------------------------------------------------------------------
interface ddr3_avl_bridge_if;
    import ddr3_avl_pkg::*;

    logic                   mem_valid;
    logic                   mem_instr;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wstrb;
    logic                   mem_ready;
    logic [31:0]            mem_rdata;

    logic [WORD_ADDR_W-1:0] avl_address;
    logic [31:0]            avl_writedata;
    logic                   avl_read;
    logic                   avl_write;
    logic                   avl_ready;
    logic [31:0]            avl_readdata;
    logic                   avl_readdatavalid;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output avl_address, avl_writedata, avl_read, avl_write,
        input  avl_ready, avl_readdata, avl_readdatavalid
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  avl_address, avl_writedata, avl_read, avl_write,
        output avl_ready, avl_readdata, avl_readdatavalid
    );

endinterface

// File: rtl/ddr3_avl_bridge.sv
// ---------------------------------------------------------------------------
// ddr3_avl_bridge
// Sequences picorv32 native memory requests that fall in the DDR window onto
// the DDR3 EMIF Avalon-MM port. The EMIF has no byte enables, so partial
// stores are done as read-modify-write. Requests are held off until EMIF
// calibration completes, reads that never return are timed out, and data
// that arrives after a timeout is discarded.
// Ports:
//   clk             : system clock
//   reset           : synchronous, active-high reset
//   bus             : cpu + EMIF bundle (slave modport)
//   local_init_done : EMIF calibration complete
//   timeout_err     : sticky flag, set when a read timed out
// ---------------------------------------------------------------------------
module ddr3_avl_bridge
    import ddr3_avl_pkg::*;
#(
    parameter logic [31:0] DDR_BASE       = 32'h0100_0000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    ddr3_avl_bridge_if.slave bus,
    input  logic             local_init_done,
    output logic             timeout_err
);

    // The wait counter only has to reach TIMEOUT_CYCLES-1.
    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam int                   WIN_TAG_W = 32 - WIN_BYTE_W;
    localparam logic [WIN_TAG_W-1:0] WIN_TAG   = DDR_BASE[31:WIN_BYTE_W];

    state_e                 state_reg;
    state_e                 state_next;

    logic [WORD_ADDR_W-1:0] addr_reg;
    logic [31:0]            wdata_reg;
    logic [31:0]            rdata_reg;
    logic [3:0]             strb_reg;
    logic [WAIT_W-1:0]      wait_cnt_reg;
    logic [WAIT_W-1:0]      wait_cnt_next;
    logic [DROP_W-1:0]      drop_cnt_reg;
    logic [DROP_W-1:0]      drop_cnt_next;
    logic                   timeout_err_reg;

    logic                   hit;
    logic                   in_wait;
    logic                   drop_pending;
    logic                   data_ok;
    logic                   wait_expired;

    logic                   read_cmd;
    logic                   write_cmd;
    logic                   resp_pulse;

    // Only the DDR window is ours; anything else is left for other slaves.
    assign hit = bus.mem_valid && (bus.mem_addr[31:WIN_BYTE_W] == WIN_TAG);

    assign in_wait      = (state_reg == ST_RD_WAIT) || (state_reg == ST_RMW_WAIT);
    assign drop_pending = (drop_cnt_reg != '0);

    // While abandoned reads are outstanding, the next returns belong to them.
    assign data_ok      = bus.avl_readdatavalid && !drop_pending;
    assign wait_expired = in_wait && !data_ok && (wait_cnt_reg == WAIT_LAST);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: begin
                // Calibration loss after this point is deliberately not tracked.
                if (local_init_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (hit) begin
                    if (bus.mem_wstrb == 4'h0) begin
                        state_next = ST_RD_ISSUE;
                    end else if (bus.mem_wstrb == 4'hF) begin
                        state_next = ST_WR_ISSUE;
                    end else begin
                        state_next = ST_RMW_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (bus.avl_ready) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RMW_ISSUE: begin
                if (bus.avl_ready) begin
                    state_next = ST_RMW_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (data_ok || wait_expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_RMW_WAIT: begin
                // A timed-out RMW abandons the store rather than writing a
                // word merged with garbage.
                if (data_ok) begin
                    state_next = ST_WR_ISSUE;
                end else if (wait_expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_WR_ISSUE: begin
                if (bus.avl_ready) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode: commands and the completion pulse follow the state
    // directly, so read and write can never be high together.
    // -----------------------------------------------------------------------
    always_comb begin
        read_cmd   = 1'b0;
        write_cmd  = 1'b0;
        resp_pulse = 1'b0;
        case (state_reg)
            ST_RD_ISSUE,
            ST_RMW_ISSUE: read_cmd   = 1'b1;
            ST_WR_ISSUE:  write_cmd  = 1'b1;
            ST_RESP:      resp_pulse = 1'b1;
            default:      ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters
    // -----------------------------------------------------------------------
    // Counts cycles spent in one WAIT state; any state change clears it, so
    // it always starts from zero on entry.
    assign wait_cnt_next = (in_wait && (state_next == state_reg))
                         ? wait_cnt_reg + 1'b1 : '0;

    // Late-data bookkeeping: a discarded beat and a fresh timeout can land in
    // the same cycle, so both adjustments are applied.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (bus.avl_readdatavalid && drop_pending) begin
            drop_cnt_next = drop_cnt_next - 1'b1;
        end
        if (wait_expired && (drop_cnt_next != DROP_MAX)) begin
            drop_cnt_next = drop_cnt_next + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            strb_reg        <= '0;
            wait_cnt_reg    <= '0;
            drop_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            drop_cnt_reg <= drop_cnt_next;

            if ((state_reg == ST_IDLE) && hit) begin
                addr_reg  <= bus.mem_addr[WIN_BYTE_W-1:2];
                wdata_reg <= bus.mem_wdata;
                strb_reg  <= bus.mem_wstrb;
            end

            if (state_reg == ST_RD_WAIT) begin
                if (data_ok) begin
                    rdata_reg <= bus.avl_readdata;
                end else if (wait_expired) begin
                    rdata_reg <= ERR_WORD;
                end
            end

            // The merged word replaces the store data and goes out on the write.
            if ((state_reg == ST_RMW_WAIT) && data_ok) begin
                wdata_reg <= merge_bytes(wdata_reg, bus.avl_readdata, strb_reg);
            end

            if (wait_expired) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign bus.mem_ready     = resp_pulse;
    assign bus.mem_rdata     = rdata_reg;
    assign bus.avl_address   = addr_reg;
    assign bus.avl_writedata = wdata_reg;
    assign bus.avl_read      = read_cmd;
    assign bus.avl_write     = write_cmd;
    assign timeout_err       = timeout_err_reg;

    // Fetch flag and byte-offset bits play no part in the word-wide EMIF access.
    logic unused_inputs;
    assign unused_inputs = ^{bus.mem_instr, bus.mem_addr[1:0]};

endmodule

// File: tb/tb_ddr3_avl_bridge.sv
// ---------------------------------------------------------------------------
// tb_ddr3_avl_bridge
// Directed bench for ddr3_avl_bridge: init gating, read latency, full write
// under backpressure, read-modify-write merge, read timeout with late-data
// discard, non-window requests and reset in the middle of a read.
// ---------------------------------------------------------------------------
module tb_ddr3_avl_bridge;
    import ddr3_avl_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic local_init_done;
    logic timeout_err;

    int checks = 0;
    int errors = 0;

    // Bus activity monitors, counted per clock.
    int          rd_high  = 0;
    int          wr_high  = 0;
    int          rd_cmds  = 0;
    int          wr_cmds  = 0;
    int          rdy_cnt  = 0;
    int          both_cnt = 0;
    logic [31:0] wr_last  = 32'h0;

    int rh0, wh0, rc0, wc0, rdy0;

    ddr3_avl_bridge_if bus();

    ddr3_avl_bridge #(
        .DDR_BASE       (32'h0100_0000),
        .TIMEOUT_CYCLES (TO),
        .ERR_WORD       (32'hDEAD_BEEF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .local_init_done (local_init_done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.avl_read === 1'b1) rd_high <= rd_high + 1;
        if (bus.avl_write === 1'b1) wr_high <= wr_high + 1;
        if (bus.avl_read === 1'b1 && bus.avl_ready === 1'b1) rd_cmds <= rd_cmds + 1;
        if (bus.avl_write === 1'b1 && bus.avl_ready === 1'b1) begin
            wr_cmds <= wr_cmds + 1;
            wr_last <= bus.avl_writedata;
        end
        if (bus.mem_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
        if (bus.avl_read === 1'b1 && bus.avl_write === 1'b1) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return bus.avl_read;
            1:       return bus.avl_write;
            default: return bus.mem_ready;
        endcase
    endfunction

    // Bounded wait (at negedges) for avl_read(0) / avl_write(1) / mem_ready(2).
    task automatic wait_for(input int sel, input string tag);
        int n;
        n = 0;
        while (sel_val(sel) !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel_val(sel)), 32'd1);
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = strb;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_mem_ready"},     32'(bus.mem_ready),   32'h0);
        chk({pfx, "_avl_read"},      32'(bus.avl_read),    32'h0);
        chk({pfx, "_avl_write"},     32'(bus.avl_write),   32'h0);
        chk({pfx, "_timeout_err"},   32'(timeout_err),     32'h0);
        chk({pfx, "_mem_rdata"},     bus.mem_rdata,        32'h0);
        chk({pfx, "_avl_address"},   32'(bus.avl_address), 32'h0);
        chk({pfx, "_avl_writedata"}, bus.avl_writedata,    32'h0);
    endtask

    initial begin
        reset                 = 1'b1;
        local_init_done       = 1'b0;
        bus.mem_valid         = 1'b0;
        bus.mem_instr         = 1'b0;
        bus.mem_addr          = 32'h0;
        bus.mem_wdata         = 32'h0;
        bus.mem_wstrb         = 4'h0;
        bus.avl_ready         = 1'b0;
        bus.avl_readdata      = 32'h0;
        bus.avl_readdatavalid = 1'b0;
        step(3);
        check_all_zero("reset");
        reset = 1'b0;

        // ---- init gating ----
        rh0 = rd_high;
        bus.avl_ready = 1'b1;
        req(32'h0100_0000, 32'h0, 4'h0);
        step(20);
        chk("init_gate_read",  32'(rd_high - rh0), 32'd0);
        chk("init_gate_ready", 32'(bus.mem_ready), 32'd0);
        local_init_done = 1'b1;
        wait_for(0, "init_read_issue");
        chk("init_read_addr", 32'(bus.avl_address), 32'h0);
        step(1);
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h0A0B_0C0D;
        step(1);
        bus.avl_readdatavalid = 1'b0;
        wait_for(2, "init_read_ready");
        chk("init_read_data", bus.mem_rdata, 32'h0A0B_0C0D);
        $display("TXN init-gated read addr=01000000 rdata=%h", bus.mem_rdata);
        bus.mem_valid = 1'b0;
        step(2);

        // ---- read, L=3: mem_ready at accept+5 ----
        req(32'h0100_0010, 32'h0, 4'h0);          // C0
        step(1);                                   // C1
        chk("rd_issue", 32'(bus.avl_read), 32'd1);
        chk("rd_addr",  32'(bus.avl_address), 32'h4);
        step(1);                                   // C2
        chk("rd_cmd_drop", 32'(bus.avl_read), 32'd0);
        step(2);                                   // C4
        chk("rd_not_early", 32'(bus.mem_ready), 32'd0);
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h1234_5678;
        step(1);                                   // C5
        bus.avl_readdatavalid = 1'b0;
        chk("rd_ready_lat", 32'(bus.mem_ready), 32'd1);
        chk("rd_data", bus.mem_rdata, 32'h1234_5678);
        $display("TXN read addr=01000010 rdata=%h", bus.mem_rdata);
        bus.mem_valid = 1'b0;
        step(1);
        chk("rd_pulse_once", 32'(bus.mem_ready), 32'd0);
        step(1);

        // ---- full write, avl_ready low 4 cycles ----
        wh0 = wr_high; wc0 = wr_cmds; rdy0 = rdy_cnt;
        bus.avl_ready = 1'b0;
        req(32'h0100_0020, 32'hCAFE_F00D, 4'hF);   // C0
        step(1);                                   // C1
        chk("wr_issue", 32'(bus.avl_write), 32'd1);
        chk("wr_data",  bus.avl_writedata, 32'hCAFE_F00D);
        chk("wr_addr",  32'(bus.avl_address), 32'h8);
        step(4);                                   // C5
        bus.avl_ready = 1'b1;
        step(1);                                   // C6
        chk("wr_ready", 32'(bus.mem_ready), 32'd1);
        bus.mem_valid = 1'b0;
        step(1);                                   // C7
        chk("wr_held_cycles", 32'(wr_high - wh0), 32'd5);
        chk("wr_single_cmd",  32'(wr_cmds - wc0), 32'd1);
        chk("wr_one_ready",   32'(rdy_cnt - rdy0), 32'd1);
        chk("wr_keeps_rdata", bus.mem_rdata, 32'h1234_5678);
        $display("TXN write addr=01000020 wdata=cafef00d strb=f");

        // ---- read-modify-write ----
        rc0 = rd_cmds; wc0 = wr_cmds;
        req(32'h0100_0030, 32'hAABB_CCDD, 4'b0101); // C0
        step(1);                                    // C1
        chk("rmw_read",    32'(bus.avl_read), 32'd1);
        chk("rmw_no_write", 32'(bus.avl_write), 32'd0);
        step(1);                                    // C2
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h1122_3344;
        step(1);                                    // C3
        bus.avl_readdatavalid = 1'b0;
        chk("rmw_write",  32'(bus.avl_write), 32'd1);
        chk("rmw_merged", bus.avl_writedata, 32'h11BB_33DD);
        wait_for(2, "rmw_ready");
        bus.mem_valid = 1'b0;
        step(1);
        chk("rmw_one_read",  32'(rd_cmds - rc0), 32'd1);
        chk("rmw_one_write", 32'(wr_cmds - wc0), 32'd1);
        chk("rmw_wr_word",   wr_last, 32'h11BB_33DD);
        $display("TXN rmw addr=01000030 strb=5 written=%h", wr_last);

        // ---- read timeout, late data, back-to-back read ----
        req(32'h0100_0040, 32'h0, 4'h0);          // C0
        step(1);                                   // C1
        chk("to_issue", 32'(bus.avl_read), 32'd1);
        step(16);                                  // C17
        chk("to_not_yet", 32'(bus.mem_ready), 32'd0);
        chk("to_err_clr", 32'(timeout_err), 32'd0);
        step(1);                                   // C18
        chk("to_ready", 32'(bus.mem_ready), 32'd1);
        chk("to_data",  bus.mem_rdata, 32'hDEAD_BEEF);
        chk("to_err",   32'(timeout_err), 32'd1);
        $display("TXN timeout read addr=01000040 rdata=%h", bus.mem_rdata);
        req(32'h0100_0044, 32'h0, 4'h0);          // held through RESP
        step(1);                                   // C19 idle, accepts
        step(1);                                   // C20
        chk("b2b_issue", 32'(bus.avl_read), 32'd1);
        step(1);                                   // C21
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h5555_5555;     // late beat from timed-out read
        step(1);                                   // C22
        bus.avl_readdatavalid = 1'b0;
        chk("late_discard", 32'(bus.mem_ready), 32'd0);
        step(1);                                   // C23
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h600D_F00D;
        step(1);                                   // C24
        bus.avl_readdatavalid = 1'b0;
        chk("own_ready", 32'(bus.mem_ready), 32'd1);
        chk("own_data",  bus.mem_rdata, 32'h600D_F00D);
        chk("err_sticky", 32'(timeout_err), 32'd1);
        $display("TXN read after timeout addr=01000044 rdata=%h", bus.mem_rdata);
        bus.mem_valid = 1'b0;
        step(2);

        // ---- non-window request ----
        rh0 = rd_high; wh0 = wr_high; rdy0 = rdy_cnt;
        req(32'h0000_1000, 32'h0, 4'h0);
        step(10);
        chk("miss_no_read",  32'(rd_high - rh0), 32'd0);
        chk("miss_no_write", 32'(wr_high - wh0), 32'd0);
        chk("miss_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
        $display("TXN miss addr=00001000 ignored");
        bus.mem_valid = 1'b0;
        step(1);

        // ---- reset during RD_WAIT ----
        req(32'h0100_0050, 32'h0, 4'h0);          // C0
        step(2);                                   // C2, waiting
        reset         = 1'b1;
        bus.mem_valid = 1'b0;
        step(1);                                   // C3
        check_all_zero("midrst");
        reset = 1'b0;
        step(1);                                   // C4, idle
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h7777_7777;     // in-flight data after reset
        step(1);                                   // C5
        bus.avl_readdatavalid = 1'b0;
        chk("stale_no_ready", 32'(bus.mem_ready), 32'd0);
        chk("stale_no_data",  bus.mem_rdata, 32'h0);
        req(32'h0100_0060, 32'h0, 4'h0);
        step(1);                                   // C6
        chk("post_rst_issue", 32'(bus.avl_read), 32'd1);
        chk("post_rst_addr",  32'(bus.avl_address), 32'h18);
        step(2);                                   // C8
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = 32'h0102_0304;
        step(1);                                   // C9
        bus.avl_readdatavalid = 1'b0;
        chk("post_rst_ready", 32'(bus.mem_ready), 32'd1);
        chk("post_rst_data",  bus.mem_rdata, 32'h0102_0304);
        $display("TXN read after reset addr=01000060 rdata=%h", bus.mem_rdata);
        bus.mem_valid = 1'b0;
        step(2);

        chk("never_rd_and_wr", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
